// File: rtl/ram_if_pkg.sv
// Purpose : shared constants and state encoding for the half-word RAM bus
//           (used by the RAM-side responder and by the memory controller).
// Ports   : none (package).
package ram_if_pkg;

  localparam int RAM_ADDR_W = 18;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ram_state_e;

endpackage

// File: rtl/ram_half_responder_if.sv
// Purpose : request/handshake side of the half-word RAM bus (data stays a plain
//           inout net on the responder because it is a shared tristate bus).
// Ports   : ram_en/ram_wre/ram_addr from the initiator; ram_rdy/ram_busy/ram_drv
//           from the responder (ram_drv = responder is driving ram_data).
interface ram_half_responder_if #(
  parameter int ADDR_W = 18
);
  logic              ram_en;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rdy;
  logic              ram_busy;
  logic              ram_drv;

  modport master (
    output ram_en, ram_wre, ram_addr,
    input  ram_rdy, ram_busy, ram_drv
  );

  modport slave (
    input  ram_en, ram_wre, ram_addr,
    output ram_rdy, ram_busy, ram_drv
  );
endinterface

// File: rtl/ram_array_16.sv
// Purpose : 2^MEM_AW x DATA_W storage, synchronous write, combinational read.
// Latency : write lands on the rising edge with we_i high; read is same-cycle.
// Ports   : clock, we_i, addr_i, wdata_i in; rdata_o out. No reset: contents
//           survive reset by design.
module ram_array_16 #(
  parameter int MEM_AW = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**MEM_AW];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_half_responder.sv
// Purpose : RAM-side responder for the 16-bit half-word bus; one request at a
//           time, WAIT_STATES wait cycles, then a one-cycle ram_rdy pulse.
// Latency : ram_rdy in the (WAIT_STATES+1)th cycle after the accept cycle; one
//           IDLE cycle always follows DONE before the next accept.
// Ports   : clock, reset (async active-low), bus (slave modport: en/wre/addr in,
//           rdy/busy/drv out), ram_data (inout; driven only in a read DONE).
module ram_half_responder
  import ram_if_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  ram_half_responder_if.slave     bus,
  inout  wire  [DATA_W-1:0]       ram_data
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("ram_half_responder: WAIT_STATES must be within 0..15");
  end

  if (MEM_AW > ADDR_W) begin : g_bad_aw
    $error("ram_half_responder: MEM_AW must not exceed ADDR_W");
  end

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  ram_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              wre_q, wre_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              accept;
  logic              mem_we;
  logic              drv;
  logic [DATA_W-1:0] rd_dat;

  // Address bits above MEM_AW alias onto the implemented depth.
  if (MEM_AW < ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ram_addr[ADDR_W-1:MEM_AW];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wre_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wre_q   <= wre_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wre_d   = wre_q;
    data_d  = data_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ram_en) begin
          accept  = 1'b1;
          addr_d  = bus.ram_addr[MEM_AW-1:0];
          wre_d   = bus.ram_wre;
          data_d  = ram_data;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_STATES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        // Request inputs are deliberately ignored here; the transaction runs
        // to completion even if ram_en drops.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write commits on the edge that closes DONE. An asynchronous reset during
  // DONE drops state_q before that edge, so the pending write is lost.
  assign mem_we = (state_q == DONE) && wre_q;

  // Single enable shared by the bus driver and the visible drive flag.
  assign drv    = (state_q == DONE) && !wre_q;

  ram_array_16 #(
    .MEM_AW (MEM_AW),
    .DATA_W (DATA_W)
  ) u_array (
    .clock   (clock),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (rd_dat)
  );

  assign ram_data     = drv ? rd_dat : {DATA_W{1'bz}};
  assign bus.ram_rdy  = (state_q == DONE);
  assign bus.ram_drv  = drv;
  // Busy covers the accept cycle itself (so the initiator sees it while it is
  // presenting ram_en) through DONE; gated by reset so it reads 0 in reset.
  assign bus.ram_busy = (state_q != IDLE) || (accept && reset);

endmodule
